// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Sequences the data-memory access of the instruction held in the EX->MEM
//   pipeline register over a req/ack memory port. While an access is in
//   flight it stalls the upstream pipeline registers. When the access
//   completes it releases the stall for exactly one cycle (DONE).
//
//   Optional feature: define DMEM_TIMEOUT_EN to abort an access that has
//   waited TIMEOUT cycles without an ack. An abort pulses dmem_err and, for
//   loads, returns load_data=0.
//
// Parameters
//   AW       address width
//   DW       data width (byte enables are DW/8 wide)
//   TIMEOUT  WAIT cycles before abort (DMEM_TIMEOUT_EN only), >= 1
//
// Ports
//   clk, reset                     clock, async active-high reset
//   mem_valid/load/be/addr/wdata   MEM-stage instruction fields
//   mem_flush                      kill the MEM-stage instruction (IDLE only)
//   dmem_req/we/be/addr/wdata      registered memory request
//   dmem_ack, dmem_rdata           memory completion and read data
//   pipe_stall                     hold the upstream pipeline registers
//   load_valid, load_data          one-cycle load result for MEM/WB
//   dmem_err                       one-cycle abort pulse
module dmem_access_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_valid,
  input  logic            mem_load,
  input  logic [DW/8-1:0] mem_be,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_wdata,
  input  logic            mem_flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [DW/8-1:0] dmem_be,
  output logic [AW-1:0]   dmem_addr,
  output logic [DW-1:0]   dmem_wdata,
  input  logic            dmem_ack,
  input  logic [DW-1:0]   dmem_rdata,
  output logic            pipe_stall,
  output logic            load_valid,
  output logic [DW-1:0]   load_data,
  output logic            dmem_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("dmem_access_ctrl: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;

  // A load wins over nonzero byte enables.
  logic access;
  assign access = mem_valid & ~mem_flush & (mem_load | (|mem_be));

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] count;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      dmem_err   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      count      <= '0;
`endif
    end else begin
      // Result pulses last only for the DONE cycle.
      load_valid <= 1'b0;
      dmem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ~mem_load;
            dmem_be    <= mem_load ? '1 : mem_be;
            dmem_addr  <= mem_addr;
            dmem_wdata <= mem_wdata;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // Request fields are frozen; mem_flush has no effect once on the bus.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              load_data  <= dmem_rdata;
              load_valid <= 1'b1;
            end
            state <= DONE;
`ifdef DMEM_TIMEOUT_EN
            count <= '0;
          end else if (count == CW'(TIMEOUT - 1)) begin
            // Abort: the ack check above gives a same-cycle ack priority.
            dmem_req <= 1'b0;
            dmem_err <= 1'b1;
            if (!dmem_we) begin
              load_data  <= '0;
              load_valid <= 1'b1;
            end
            count <= '0;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
`endif
          end
        end
        // Inputs still show the completed instruction; never restart here.
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is combinational so the IDLE-cycle request fields cannot move
  // before they are latched. It is forced low while reset is held.
  always_comb begin
    pipe_stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    pipe_stall = access;
        WAIT:    pipe_stall = 1'b1;
        default: pipe_stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl (32-bit address/data, TIMEOUT=4).
// The timeout cases run only when DMEM_TIMEOUT_EN is defined.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_load, mem_flush;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        pipe_stall, load_valid, dmem_err;
  logic [31:0] load_data;

  int errs = 0;
  int checks = 0;

  dmem_access_ctrl #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_load(mem_load), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_flush(mem_flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pipe_stall(pipe_stall), .load_valid(load_valid),
    .load_data(load_data), .dmem_err(dmem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_load = 1'b0; mem_be = 4'h0; mem_flush = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  // Start an access in the current IDLE cycle, ack it in WAIT cycle ack_at
  // (0 = never), then check the request, stall length and DONE results.
  task automatic run_acc(input string tag, input logic ld, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_at, input logic fl,
                         input logic exp_we, input logic [3:0] exp_be, input int exp_stall,
                         input logic exp_lv, input logic [31:0] exp_ld, input logic exp_err);
    int  stalls;
    bit  done;
    mem_valid = 1'b1; mem_load = ld; mem_be = be; mem_addr = addr; mem_wdata = wdata;
    #1;
    chk({tag, "_stall_idle"}, pipe_stall, 1'b1);
    stalls = 1;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      cyc();
      if (!pipe_stall) begin
        done = 1;
      end else begin
        stalls++;
        if (c == 0) begin
          chk({tag, "_req"},  dmem_req,  1'b1);
          chk({tag, "_we"},   dmem_we,   exp_we);
          chk({tag, "_be"},   dmem_be,   exp_be);
          chk({tag, "_addr"}, dmem_addr, addr);
          if (exp_we) chk({tag, "_wdata"}, dmem_wdata, wdata);
          if (fl) begin
            mem_flush = 1'b1;
            mem_addr  = ~addr;
          end
        end
        dmem_ack   = (c + 1 == ack_at);
        dmem_rdata = rdata;
      end
    end
    chk({tag, "_completed"}, done, 1'b1);
    dmem_ack = 1'b0;
    chk({tag, "_stall_cnt"}, stalls, exp_stall);
    chk({tag, "_done_req"},  dmem_req, 1'b0);
    chk({tag, "_lv"},        load_valid, exp_lv);
    chk({tag, "_ldata"},     load_data, exp_ld);
    chk({tag, "_err"},       dmem_err, exp_err);
    if (fl) chk({tag, "_addr_held"}, dmem_addr, addr);
    cyc();
    idle_inputs();
    #1;
    chk({tag, "_lv_pulse"}, load_valid, 1'b0);
    chk({tag, "_err_pulse"}, dmem_err, 1'b0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    mem_valid = 1'b1; mem_load = 1'b1;
    #12;
    chk("rst_stall", pipe_stall, 1'b0);
    chk("rst_req",   dmem_req,   1'b0);
    chk("rst_we",    dmem_we,    1'b0);
    chk("rst_be",    dmem_be,    4'h0);
    chk("rst_addr",  dmem_addr,  32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_lv",    load_valid, 1'b0);
    chk("rst_ldata", load_data,  32'h0);
    chk("rst_err",   dmem_err,   1'b0);
    idle_inputs();
    cyc();
    reset = 1'b0;
    cyc();

    // 1. load, ack in first WAIT cycle
    run_acc("ld1", 1'b1, 4'h0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0,
            1'b0, 4'hF, 2, 1'b1, 32'hDEADBEEF, 1'b0);
    // 2. store, ack in 5th WAIT cycle; load_data untouched
    run_acc("st2", 1'b0, 4'b0011, 32'h104, 32'h1234, 32'hFFFFFFFF, 5, 1'b0,
            1'b1, 4'b0011, 6, 1'b0, 32'hDEADBEEF, 1'b0);
    // 3. back-to-back load then store
    run_acc("b2b_ld", 1'b1, 4'h0, 32'h200, 32'h0, 32'hCAFEF00D, 2, 1'b0,
            1'b0, 4'hF, 3, 1'b1, 32'hCAFEF00D, 1'b0);
    run_acc("b2b_st", 1'b0, 4'hF, 32'h204, 32'h55AA55AA, 32'h0, 1, 1'b0,
            1'b1, 4'hF, 2, 1'b0, 32'hCAFEF00D, 1'b0);
    // load with byte enables set: load wins
    run_acc("ldbe", 1'b1, 4'b0101, 32'h208, 32'h77, 32'h13579BDF, 1, 1'b0,
            1'b0, 4'hF, 2, 1'b1, 32'h13579BDF, 1'b0);

    // 4a. flush in IDLE: no request, no stall
    mem_valid = 1'b1; mem_load = 1'b1; mem_addr = 32'h300; mem_flush = 1'b1;
    #1;
    chk("flush_idle_stall", pipe_stall, 1'b0);
    cyc();
    chk("flush_idle_req", dmem_req, 1'b0);
    chk("flush_idle_stall2", pipe_stall, 1'b0);
    idle_inputs();
    // ack while IDLE is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    cyc();
    dmem_ack = 1'b0;
    #1;
    chk("ack_idle_lv", load_valid, 1'b0);
    chk("ack_idle_req", dmem_req, 1'b0);
    chk("ack_idle_ldata", load_data, 32'h13579BDF);
    // 4b. flush during WAIT: access completes normally
    run_acc("flush_wait", 1'b1, 4'h0, 32'h300, 32'h0, 32'h0BADF00D, 3, 1'b1,
            1'b0, 4'hF, 4, 1'b1, 32'h0BADF00D, 1'b0);

    // 5. reset during WAIT
    mem_valid = 1'b1; mem_load = 1'b1; mem_addr = 32'h500;
    cyc();
    chk("rstw_req_before", dmem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk("rstw_req",   dmem_req,   1'b0);
    chk("rstw_stall", pipe_stall, 1'b0);
    chk("rstw_lv",    load_valid, 1'b0);
    cyc();
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("rstw_idle_stall", pipe_stall, 1'b0);
    cyc();
    chk("rstw_idle_req", dmem_req, 1'b0);
    run_acc("post_rst", 1'b1, 4'h0, 32'h504, 32'h0, 32'hA5A5A5A5, 1, 1'b0,
            1'b0, 4'hF, 2, 1'b1, 32'hA5A5A5A5, 1'b0);

`ifdef DMEM_TIMEOUT_EN
    // 6. timeout: 4 WAIT cycles, abort with error and zero load data
    run_acc("to_ld", 1'b1, 4'h0, 32'h600, 32'h0, 32'h0, 0, 1'b0,
            1'b0, 4'hF, 5, 1'b1, 32'h0, 1'b1);
    run_acc("to_st", 1'b0, 4'hC, 32'h604, 32'h99, 32'h0, 0, 1'b0,
            1'b1, 4'hC, 5, 1'b0, 32'h0, 1'b1);
    // ack on the timeout cycle wins
    run_acc("to_ack", 1'b1, 4'h0, 32'h608, 32'h0, 32'h2468ACE0, 4, 1'b0,
            1'b0, 4'hF, 5, 1'b1, 32'h2468ACE0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
